bsg_arb_rr_lock: RTL and testbench
==================================

// Module: bsg_arb_rr_lock
//
// PURPOSE
// - Round-robin arbiter that shares one downstream resource among width_p requesters.
// - Output is a one-hot grant plus its binary index, built from rotated priority-encode logic.
// - Grant is combinational from requests. The round-robin pointer and lock state update on accepted grants.
// - A requester can lock the arbiter to itself for multi-beat transfers.
//
// PARAMETERS
// - width_p     16                 number of requesters; must be >= 1
// - lg_width_p  `BSG_SAFE_CLOG2(width_p)   width of the index and pointer; derived, do not override
//
// PORTS
// - clk_i        in   1            clock; all state updates on the rising edge
// - reset_i      in   1            synchronous, active-high reset
// - reqs_i       in   width_p      request vector; bit n = requester n
// - lock_i       in   1            sampled with yumi_i; 1 = hold this grant on later cycles
// - v_o          out  1            a grant is valid this cycle
// - grants_o     out  width_p      one-hot grant; all zero when v_o=0
// - tag_o        out  lg_width_p   index of the granted requester; 0 when v_o=0
// - yumi_i       in   1            consumer accepts the grant this cycle; legal only when v_o=1
//
// BEHAVIOUR
// - State: last_r (lg_width_p bits), state_r {IDLE, LOCKED}, lock_id_r (lg_width_p bits).
// - Reset values: last_r = width_p-1, state_r = IDLE, lock_id_r = 0.
//   - So after reset requester 0 has highest priority.
//   - Outputs follow reqs_i through the IDLE rules below.
// - IDLE arbitration:
//   - Search starts at index last_r+1 (mod width_p) and wraps upward.
//   - The first set bit of reqs_i wins.
//   - v_o = |reqs_i.
// - LOCKED arbitration:
//   - Only lock_id_r is eligible.
//   - v_o = reqs_i[lock_id_r]; grants_o = v_o << lock_id_r.
//   - Other requests are ignored.
//   - If the locked requester drops its request, v_o=0 and the arbiter stays LOCKED. There is no timeout.
// - Latency: 0 cycles from reqs_i to v_o/grants_o/tag_o. 1 cycle from an accept to the pointer/lock update.
// - On (v_o & yumi_i):
//   - last_r <= tag_o.
//   - IDLE & lock_i: state_r <= LOCKED, lock_id_r <= tag_o.
//   - LOCKED & !lock_i: state_r <= IDLE.
//   - Otherwise state_r is unchanged.
// - No accept (yumi_i=0): no state change.
//   - reqs_i may change freely.
//   - Grants need not be stable while unaccepted.
// - yumi_i=1 with v_o=0 is a protocol error.
//   - Flag it with a simulation-only error message.
//   - State is unchanged.
// - Pointer arithmetic is modulo width_p. For non-power-of-2 width_p, last_r+1 wraps from width_p-1 to 0.
// - width_p=1: tag_o=0, grants_o=reqs_i, and the pointer has no effect. Locking still functions.
// - Reset asserted mid-operation, including while LOCKED: the next cycle is IDLE with last_r=width_p-1.
// - reqs_i must not be X while reset_i=0. Outputs are don't-care during reset.
//
// CONFIGURATION
// - BSG_ARB_RR_LOCK_STALL_CNT_EN defined:
//   - Adds output port stall_cnt_o [15:0].
//   - It is a saturating counter of cycles where v_o=1 & yumi_i=0.
//   - Reset value 0. It holds at 16'hFFFF and is never cleared except by reset_i.
// - Not defined: the port and counter are absent. Arbitration behaviour is identical either way.
//
// TESTING (width_p=4 unless noted)
// - After reset, reqs_i=4'b1111, yumi_i=1 every cycle -> tag_o sequence 0,1,2,3,0; grants_o 0001,0010,0100,1000,0001.
// - Accept tag 1, then reqs_i=4'b1010 with yumi_i=1 -> tag_o=3, then 1, then 3 (wrap past 0 is skipped).
// - reqs_i=4'b1111, accept tag 0 with lock_i=1, then 3 accepts with lock_i=1 -> tag_o=0 each time.
//   - Then accept with lock_i=0 -> next tag_o=1.
// - LOCKED on 0, then reqs_i=4'b1110 -> v_o=0, grants_o=0000, tag_o=0.
//   - Restore reqs_i=4'b1111 -> tag_o=0 again.
// - LOCKED on 2, assert reset_i one cycle with reqs_i=4'b0110 -> after reset tag_o=1, state IDLE.
// - With the macro defined: v_o=1, yumi_i=0 for 5 cycles -> stall_cnt_o=5.
//   - Force the counter near 16'hFFFF -> it holds at 16'hFFFF.
// - width_p=3, reqs_i=3'b111, yumi_i=1 -> tag_o 0,1,2,0 (modulo wrap, non-power-of-2).

Source files
------------

// File: rtl/bsg_arb_rr_lock.sv
// bsg_arb_rr_lock: round-robin arbiter with requester lock for multi-beat transfers.
//
// The grant is combinational from reqs_i. The round-robin pointer and the lock
// state update on the clock edge after an accepted grant (v_o & yumi_i).
//
// Optional feature macro: BSG_ARB_RR_LOCK_STALL_CNT_EN adds stall_cnt_o, a
// saturating count of cycles with v_o=1 and yumi_i=0.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   reqs_i       request vector, bit n = requester n
//   lock_i       sampled with yumi_i; 1 = keep granting this requester
//   yumi_i       consumer accepts the current grant (only legal when v_o=1)
//   v_o          a grant is valid this cycle
//   grants_o     one-hot grant, zero when v_o=0
//   tag_o        binary index of the granted requester, zero when v_o=0
//   stall_cnt_o  (macro only) saturating stall-cycle counter
module bsg_arb_rr_lock #(
  parameter int unsigned width_p    = 16,
  parameter int unsigned lg_width_p = (width_p <= 1) ? 1 : $clog2(width_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [width_p-1:0]    reqs_i,
  input  logic                  lock_i,
  input  logic                  yumi_i,
  output logic                  v_o,
  output logic [width_p-1:0]    grants_o,
  output logic [lg_width_p-1:0] tag_o
`ifdef BSG_ARB_RR_LOCK_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  typedef enum logic {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } state_e;

  localparam logic [lg_width_p-1:0] last_reset_lp = lg_width_p'(width_p - 1);

  state_e                state_q, state_d;
  logic [lg_width_p-1:0] last_q, last_d;
  logic [lg_width_p-1:0] lock_id_q, lock_id_d;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_idle;
      last_q    <= last_reset_lp;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Next-state: pointer and lock only move on an accepted grant
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    lock_id_d = lock_id_q;
    if (v_o && yumi_i) begin
      last_d = tag_o;
      if ((state_q == e_idle) && lock_i) begin
        state_d   = e_locked;
        lock_id_d = tag_o;
      end else if ((state_q == e_locked) && !lock_i) begin
        state_d = e_idle;
      end
    end
  end

  // Output: rotated priority search starting one past the last winner.
  // Index math is done in 32 bits so non-power-of-2 widths wrap at width_p.
  always_comb begin
    logic                  found;
    logic [lg_width_p-1:0] idx_l;
    int unsigned           start;
    int unsigned           idx;

    found = 1'b0;
    tag_o = '0;
    idx_l = '0;
    idx   = 0;
    start = 32'(last_q) + 32'd1;
    if (start >= width_p) start = 0;

    if (state_q == e_locked) begin
      found = reqs_i[lock_id_q];
      if (found) tag_o = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < width_p; k++) begin
        idx = start + k;
        if (idx >= width_p) idx = idx - width_p;
        idx_l = lg_width_p'(idx);
        if (!found && reqs_i[idx_l]) begin
          found = 1'b1;
          tag_o = idx_l;
        end
      end
    end

    v_o      = found;
    grants_o = found ? (width_p'(1) << tag_o) : '0;
  end

`ifdef BSG_ARB_RR_LOCK_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of offered-but-not-accepted cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v_o && !yumi_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // Accepting with no valid grant is a consumer bug; state is left unchanged
  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i && !v_o) begin
      $error("bsg_arb_rr_lock: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_arb_rr_lock.sv
// Bench for bsg_arb_rr_lock: directed sequences with literal expectations on a
// width-4 instance and a width-3 instance, then randomized traffic, all
// compared every cycle against a behavioural arbiter model.
module tb_bsg_arb_rr_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] reqs4;
  logic       lock4, yumi4, v4;
  logic [3:0] grants4;
  logic [1:0] tag4;
  logic [2:0] reqs3;
  logic       lock3, yumi3, v3;
  logic [2:0] grants3;
  logic [1:0] tag3;
`ifdef BSG_ARB_RR_LOCK_STALL_CNT_EN
  logic [15:0] stall4, stall3;
`endif

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = width 4, 1 = width 3
  int m_last[2];
  bit m_locked[2];
  int m_lid[2];
  int m_stall[2];

  always #5 clk = ~clk;

  bsg_arb_rr_lock #(.width_p(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .reqs_i(reqs4), .lock_i(lock4), .yumi_i(yumi4),
    .v_o(v4), .grants_o(grants4), .tag_o(tag4)
`ifdef BSG_ARB_RR_LOCK_STALL_CNT_EN
    , .stall_cnt_o(stall4)
`endif
  );

  bsg_arb_rr_lock #(.width_p(3)) dut3 (
    .clk_i(clk), .reset_i(rst), .reqs_i(reqs3), .lock_i(lock3), .yumi_i(yumi3),
    .v_o(v3), .grants_o(grants3), .tag_o(tag3)
`ifdef BSG_ARB_RR_LOCK_STALL_CNT_EN
    , .stall_cnt_o(stall3)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner under the round-robin/lock rules, or -1 when nothing is granted
  function automatic int model_tag(input int w, input int r, input int last,
                                   input bit locked, input int lid);
    if (locked) return ((r >> lid) & 1) != 0 ? lid : -1;
    for (int k = 1; k <= w; k++) begin
      int i;
      i = (last + k) % w;
      if (((r >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_last[n]   = (n == 0) ? 3 : 2;
      m_locked[n] = 1'b0;
      m_lid[n]    = 0;
      m_stall[n]  = 0;
    end
  endtask

  task automatic model_step(input int n, input int w, input int r, input bit y, input bit l);
    int t;
    t = model_tag(w, r, m_last[n], m_locked[n], m_lid[n]);
    if (t >= 0 && !y) m_stall[n] = (m_stall[n] == 65535) ? 65535 : m_stall[n] + 1;
    if (t >= 0 && y) begin
      m_last[n] = t;
      if (!m_locked[n] && l) begin
        m_locked[n] = 1'b1;
        m_lid[n]    = t;
      end else if (m_locked[n] && !l) begin
        m_locked[n] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      model_step(0, 4, 32'(reqs4), yumi4, lock4);
      model_step(1, 3, 32'(reqs3), yumi3, lock3);
    end
  end

  task automatic cmp(input int n, input int w, input int r, input int v, input int tag, input int g);
    int t;
    int ev;
    t  = model_tag(w, r, m_last[n], m_locked[n], m_lid[n]);
    ev = (t >= 0) ? 1 : 0;
    chk($sformatf("v_w%0d", w), v, ev);
    chk($sformatf("tag_w%0d", w), tag, ev != 0 ? t : 0);
    chk($sformatf("grants_w%0d", w), g, ev != 0 ? (1 << t) : 0);
  endtask

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, 4, 32'(reqs4), 32'(v4), 32'(tag4), 32'(grants4));
      cmp(1, 3, 32'(reqs3), 32'(v3), 32'(tag3), 32'(grants3));
`ifdef BSG_ARB_RR_LOCK_STALL_CNT_EN
      chk("stall_w4", 32'(stall4), m_stall[0]);
      chk("stall_w3", 32'(stall3), m_stall[1]);
`endif
    end
  end

  // One cycle on the width-4 instance with an optional literal expectation
  task automatic step4(input logic [3:0] r, input logic y, input logic l,
                       input int ev, input int et);
    reqs4 = r; yumi4 = y; lock4 = l;
    @(negedge clk);
    if (et >= 0) begin
      chk("lit_v_w4", 32'(v4), ev);
      chk("lit_tag_w4", 32'(tag4), et);
      chk("lit_grants_w4", 32'(grants4), ev != 0 ? (1 << et) : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic step3(input logic [2:0] r, input logic y, input int et);
    reqs3 = r; yumi3 = y; lock3 = 1'b0;
    @(negedge clk);
    chk("lit_tag_w3", 32'(tag3), et);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1; reqs4 = r; yumi4 = 1'b0; lock4 = 1'b0;
    reqs3 = '0; yumi3 = 1'b0; lock3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int t4, t3;
    rst = 1'b1;
    reqs4 = '0; lock4 = 1'b0; yumi4 = 1'b0;
    reqs3 = '0; lock3 = 1'b0; yumi3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full requests rotate 0,1,2,3,0 from reset
    step4(4'b1111, 1'b1, 1'b0, 1, 0);
    step4(4'b1111, 1'b1, 1'b0, 1, 1);
    step4(4'b1111, 1'b1, 1'b0, 1, 2);
    step4(4'b1111, 1'b1, 1'b0, 1, 3);
    step4(4'b1111, 1'b1, 1'b0, 1, 0);
    // Accept tag 1, then sparse requests alternate 3,1,3
    step4(4'b1111, 1'b1, 1'b0, 1, 1);
    step4(4'b1010, 1'b1, 1'b0, 1, 3);
    step4(4'b1010, 1'b1, 1'b0, 1, 1);
    step4(4'b1010, 1'b1, 1'b0, 1, 3);
    // Lock on 0 for several beats, release, then round-robin resumes at 1
    step4(4'b1111, 1'b1, 1'b1, 1, 0);
    repeat (3) step4(4'b1111, 1'b1, 1'b1, 1, 0);
    step4(4'b1111, 1'b1, 1'b0, 1, 0);
    step4(4'b1111, 1'b0, 1'b0, 1, 1);
    // Locked requester drops: no grant, lock held
    step4(4'b0001, 1'b1, 1'b1, 1, 0);
    step4(4'b1110, 1'b0, 1'b0, 0, 0);
    step4(4'b1110, 1'b0, 1'b0, 0, 0);
    step4(4'b1111, 1'b1, 1'b1, 1, 0);
    // Lock on 2 then reset: back to IDLE with requester 0 highest priority
    step4(4'b1111, 1'b1, 1'b0, 1, 0);
    step4(4'b0100, 1'b1, 1'b1, 1, 2);
    step4(4'b0110, 1'b0, 1'b1, 1, 2);
    do_reset(4'b0110);
    step4(4'b0110, 1'b0, 1'b0, 1, 1);
    step4(4'b0100, 1'b0, 1'b0, 1, 2);
    step4(4'b0000, 1'b0, 1'b0, 0, 0);
    // Stall cycles with the width-4 grant held
    repeat (5) step4(4'b1000, 1'b0, 1'b0, 1, 3);

    // Non-power-of-2 wrap on width 3
    step3(3'b111, 1'b1, 0);
    step3(3'b111, 1'b1, 1);
    step3(3'b111, 1'b1, 2);
    step3(3'b111, 1'b1, 0);
    step3(3'b101, 1'b1, 2);
    step3(3'b101, 1'b1, 0);

    // Randomized traffic on both instances, accepts only when a grant exists
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(4'($urandom));
      end else begin
        reqs4 = 4'($urandom);
        reqs3 = 3'($urandom);
        if ($urandom_range(0, 3) == 0) reqs4 = 4'b0000;
        lock4 = ($urandom_range(0, 2) == 0);
        lock3 = ($urandom_range(0, 2) == 0);
        t4 = model_tag(4, 32'(reqs4), m_last[0], m_locked[0], m_lid[0]);
        t3 = model_tag(3, 32'(reqs3), m_last[1], m_locked[1], m_lid[1]);
        yumi4 = (t4 >= 0) && ($urandom_range(0, 3) != 0);
        yumi3 = (t3 >= 0) && ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end

    yumi4 = 1'b0; yumi3 = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
